// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between the execute path (port 0)
// and an auxiliary unit (port 1); operands and result are registered around the ALU.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,

   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_c,
   output logic             rsp0_zero,
   output logic             rsp0_sgn,

   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_c,
   output logic             rsp1_zero,
   output logic             rsp1_sgn,

   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_zero,
   input  logic             alu_sgn
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [OPW-1:0]     op_q;
   logic [WIDTH-1:0]   a_q, b_q, c_q;
   logic               owner_q, zero_q, sgn_q, last_q;

   logic               grant_port;
   logic               hs;

   // The ALU only ever sees registered operands; rsp data is always the result register.
   assign alu_op    = op_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;

   assign rsp0_c    = c_q;
   assign rsp0_zero = zero_q;
   assign rsp0_sgn  = sgn_q;
   assign rsp1_c    = c_q;
   assign rsp1_zero = zero_q;
   assign rsp1_sgn  = sgn_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can infer a latch.
      state_d    = state_q;
      grant_port = 1'b0;
      hs         = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;

      case (state_q)
         IDLE: begin
            // On a tie the port that did not win last time goes next.
            if (req0_valid && req1_valid) begin
               grant_port = ~last_q;
            end else begin
               grant_port = req1_valid;
            end
            req0_ready = ~rst & req0_valid & ~grant_port;
            req1_ready = ~rst & req1_valid &  grant_port;
            hs         = req0_ready | req1_ready;
            if (hs) begin
               state_d = EXEC;
            end
         end

         EXEC: begin
            state_d = RESP;
         end

         RESP: begin
            rsp0_valid = ~rst & ~owner_q;
            rsp1_valid = ~rst &  owner_q;
            if (owner_q ? rsp1_ready : rsp0_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath flops are reset too; they are few, and it keeps alu_* and rsp*_c defined after reset.
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         owner_q <= 1'b0;
         c_q     <= '0;
         zero_q  <= 1'b0;
         sgn_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         if (hs) begin
            op_q    <= grant_port ? req1_op : req0_op;
            a_q     <= grant_port ? req1_a  : req0_a;
            b_q     <= grant_port ? req1_b  : req0_b;
            owner_q <= grant_port;
            last_q  <= grant_port;
         end
         if (state_q == EXEC) begin
            c_q    <= alu_c;
            zero_q <= alu_zero;
            sgn_q  <= alu_sgn;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU stands in for the real one,
// a monitor checks grants, latency and responses against the arbitration rules.
module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLL = 4'd5;
   localparam logic [3:0] OP_SRA = 4'd7;

   logic        clk, rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_sgn;
   logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_sgn;
   logic [31:0] rsp0_c, rsp1_c;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_c;
   logic        alu_zero, alu_sgn;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        z;
      logic        s;
      int          t;
   } entry_t;

   entry_t      sb0[$];
   entry_t      sb1[$];
   bit          seen[2];
   int          grant_log[$];
   int          model_last;
   int          cyc;
   int          n_rsp[2];
   logic [31:0] cap_c[2];
   logic        cap_z[2];
   logic        cap_s[2];
   logic [31:0] cap_alu_b[2];
   int          checks, failures;
   bit          rand_stop;

   alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_zero(rsp0_zero), .rsp0_sgn(rsp0_sgn),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_zero(rsp1_zero), .rsp1_sgn(rsp1_sgn),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_c(alu_c), .alu_zero(alu_zero), .alu_sgn(alu_sgn)
   );

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd5:    r = a << b[4:0];
         4'd6:    r = a >> b[4:0];
         4'd7:    r = 32'($signed(a) >>> b[4:0]);
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   assign alu_c    = alu_fn(alu_op, alu_a, alu_b);
   assign alu_zero = (alu_c == 32'd0);
   assign alu_sgn  = alu_c[31];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      entry_t e;
      e.op = op;
      e.a  = a;
      e.b  = b;
      e.c  = alu_fn(op, a, b);
      e.z  = (e.c == 32'd0);
      e.s  = e.c[31];
      e.t  = cyc;
      if (p == 0) sb0.push_back(e);
      else sb1.push_back(e);
      grant_log.push_back(p);
      model_last = p;
   endtask

   task automatic check_rsp(input int p, input logic v, input logic rdy,
                            input logic [31:0] c, input logic z, input logic s);
      entry_t e;
      if (!v) return;
      if ((p == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
         check($sformatf("rsp%0d_spurious_valid", p), 64'd1, 64'd0);
         return;
      end
      e = (p == 0) ? sb0[0] : sb1[0];
      check($sformatf("rsp%0d_c", p), 64'(c), 64'(e.c));
      check($sformatf("rsp%0d_zero", p), 64'(z), 64'(e.z));
      check($sformatf("rsp%0d_sgn", p), 64'(s), 64'(e.s));
      check($sformatf("rsp%0d_alu_in", p), {28'd0, alu_op, alu_a}, {28'd0, e.op, e.a});
      check($sformatf("rsp%0d_alu_b", p), 64'(alu_b), 64'(e.b));
      if (!seen[p]) begin
         check($sformatf("rsp%0d_latency", p), 64'(cyc), 64'(e.t + 2));
         seen[p] = 1'b1;
      end
      if (rdy) begin
         cap_c[p]     = c;
         cap_z[p]     = z;
         cap_s[p]     = s;
         cap_alu_b[p] = alu_b;
         n_rsp[p]++;
         seen[p]      = 1'b0;
         if (p == 0) void'(sb0.pop_front());
         else void'(sb1.pop_front());
      end
   endtask

   // Monitor: samples on the falling edge, away from where the DUT updates.
   always @(negedge clk) begin
      logic [1:0] exp_rdy;
      if (rst) begin
         check("rst_outputs_low", {60'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 64'd0);
         sb0.delete();
         sb1.delete();
         seen[0]    = 1'b0;
         seen[1]    = 1'b0;
         model_last = 1;
      end else begin
         if (sb0.size() + sb1.size() != 0) begin
            exp_rdy = 2'b00;
         end else if (req0_valid && req1_valid) begin
            exp_rdy = (model_last == 1) ? 2'b01 : 2'b10;
         end else begin
            exp_rdy = {req1_valid, req0_valid};
         end
         check("req_ready_grant", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
         if (req0_valid && req0_ready) push(0, req0_op, req0_a, req0_b);
         if (req1_valid && req1_ready) push(1, req1_op, req1_a, req1_b);
         check_rsp(0, rsp0_valid, rsp0_ready, rsp0_c, rsp0_zero, rsp0_sgn);
         check_rsp(1, rsp1_valid, rsp1_ready, rsp1_c, rsp1_zero, rsp1_sgn);
      end
   end

   task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit drop);
      bit done;
      done = 1'b0;
      if (p == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         done = (p == 0) ? (req0_valid & req0_ready) : (req1_valid & req1_ready);
      end
      if (!done) check($sformatf("req%0d_handshake_timeout", p), 64'd0, 64'd1);
      @(posedge clk);
      #1;
      if (drop || !done) begin
         // Scramble the payload once valid drops; only the handshake cycle should matter.
         if (p == 0) begin
            req0_valid = 1'b0; req0_op = 4'($urandom); req0_a = $urandom; req0_b = $urandom;
         end else begin
            req1_valid = 1'b0; req1_op = 4'($urandom); req1_a = $urandom; req1_b = $urandom;
         end
      end
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 400 && !idle; i++) begin
         @(posedge clk);
         #1;
         idle = (sb0.size() == 0) && (sb1.size() == 0) && !req0_valid && !req1_valid;
      end
      if (!idle) check("wait_idle_timeout", 64'd0, 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic rand_ops(input int p, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         issue(p, 4'($urandom_range(0, 7)), $urandom, $urandom, gaps || (i == n - 1));
         if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   initial begin
      int n0;
      checks = 0; failures = 0; model_last = 1; rand_stop = 1'b0;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      check("rst_c_q", 64'(rsp0_c), 64'd0);
      check("rst_alu_drive", {alu_op, alu_a, alu_b}, 68'd0);

      // Tie straight after reset: port 0 wins first.
      grant_log.delete();
      fork
         issue(0, OP_SUB, 32'd3, 32'd3, 1);
         issue(1, OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1);
      join
      wait_idle();
      check("tie_first_grant", 64'(grant_log[0]), 64'd0);
      check("tie_second_grant", 64'(grant_log[1]), 64'd1);
      check("tie_p0_c_zero", {31'd0, cap_z[0], cap_c[0]}, {31'd0, 1'b1, 32'd0});
      check("tie_p1_c_sgn", {31'd0, cap_s[1], cap_c[1]}, {31'd0, 1'b1, 32'hFFFF_FFFF});

      // Single op on port 0.
      n0 = n_rsp[1];
      issue(0, OP_ADD, 32'd5, 32'd7, 1);
      wait_idle();
      check("add_c", 64'(cap_c[0]), 64'd12);
      check("add_flags", {62'd0, cap_z[0], cap_s[0]}, 64'd0);
      check("add_no_rsp1", 64'(n_rsp[1]), 64'(n0));

      // Shift amount is passed through unmasked; the ALU masks it.
      issue(0, OP_SLL, 32'd1, 32'h21, 1);
      wait_idle();
      check("sll_c", 64'(cap_c[0]), 64'd2);
      check("sll_alu_b", 64'(cap_alu_b[0]), 64'h21);

      // Back-pressure on port 1 while port 0 waits.
      rsp1_ready = 0;
      fork
         issue(1, OP_SRA, 32'h8000_0000, 32'd4, 1);
         begin
            repeat (2) @(posedge clk);
            #1;
            issue(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1);
         end
         begin
            repeat (7) @(posedge clk);
            #1;
            check("bp_rsp1_held", {31'd0, rsp1_valid, rsp1_c}, {31'd0, 1'b1, 32'hF800_0000});
            rsp1_ready = 1;
         end
      join
      wait_idle();
      check("bp_rsp1_c", 64'(cap_c[1]), 64'hF800_0000);
      check("bp_p0_after", {31'd0, cap_z[0], cap_c[0]}, {31'd0, 1'b1, 32'd0});

      // Continuous contention: grants must alternate.
      grant_log.delete();
      fork
         rand_ops(0, 8, 0);
         rand_ops(1, 8, 0);
      join
      wait_idle();
      check("contention_count", 64'(grant_log.size()), 64'd16);
      for (int i = 1; i < grant_log.size(); i++) begin
         check($sformatf("contention_alt_%0d", i), 64'(grant_log[i]), 64'(1 - grant_log[i-1]));
      end

      // Reset during EXEC drops the transaction.
      n0 = n_rsp[0];
      issue(0, OP_ADD, 32'd1, 32'd2, 1);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      repeat (8) @(posedge clk);
      #1;
      check("rst_exec_dropped", 64'(n_rsp[0]), 64'(n0));
      grant_log.delete();
      fork
         issue(0, OP_ADD, 32'd10, 32'd20, 1);
         issue(1, OP_SUB, 32'd10, 32'd20, 1);
      join
      wait_idle();
      check("rst_exec_tie_grant", 64'(grant_log[0]), 64'd0);

      // Random traffic with gaps and random response back-pressure.
      fork
         begin
            fork
               rand_ops(0, 30, 1);
               rand_ops(1, 30, 1);
            join
            rand_stop = 1'b1;
         end
         begin
            while (!rand_stop) begin
               @(posedge clk);
               #1;
               rsp0_ready = 1'($urandom_range(0, 1));
               rsp1_ready = 1'($urandom_range(0, 1));
            end
            rsp0_ready = 1;
            rsp1_ready = 1;
         end
      join
      wait_idle();
      check("final_sb_empty", 64'(sb0.size() + sb1.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU between two requesters: port 0 is the core execute path and port 1 is an auxiliary unit (address/debug).
- Each requester sends an op and two operands over a valid/ready request channel and receives the result on a valid/ready response channel.
- Round-robin grant. Operands are registered before they drive the ALU. The result is registered before it is returned.

Parameters:
- WIDTH, 32, operand/result width
- OPW, 4, ALU op-code width (matches the ALU op encoding)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  arbiter accepts requester 0 op this cycle
- req0_op  in  OPW  ALU op
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_c  out  WIDTH  result
- rsp0_zero  out  1  result == 0
- rsp0_sgn  out  1  result[WIDTH-1]
- rsp1_valid, rsp1_ready, rsp1_c, rsp1_zero, rsp1_sgn  same as port 0, for requester 1
- alu_op  out  OPW  to ALU op
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_c  in  WIDTH  from ALU C
- alu_zero  in  1  from ALU zero
- alu_sgn  in  1  from ALU sgn

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Registers: op_q, a_q, b_q, owner_q (0/1), c_q, zero_q, sgn_q, last_q.
- Reset values: all registers 0 except last_q = 1, so port 0 wins the first tie. All valid/ready outputs are 0 while rst is high.
- ALU drive: alu_op/alu_a/alu_b = op_q/a_q/b_q at all times; there is no combinational path from req_* to the ALU. The ALU may hold stale values outside EXEC.
- IDLE, grant:
  - Only one valid: that port is granted.
  - Both valid: grant the port != last_q.
  - reqN_ready = 1 only for the granted port, and only in IDLE. reqN_ready depends combinationally on reqN_valid, on the other port's valid and on last_q. The other port's ready is 0.
- IDLE, on handshake (valid & ready):
  - latch op/a/b into op_q/a_q/b_q; owner_q <= granted port; last_q <= granted port;
  - go to EXEC.
- EXEC (one cycle): capture c_q <= alu_c, zero_q <= alu_zero, sgn_q <= alu_sgn. Go to RESP.
- RESP:
  - rsp{owner_q}_valid = 1 with rsp{owner_q}_c/zero/sgn = c_q/zero_q/sgn_q. The other rsp valid is 0.
  - Hold until rsp{owner_q}_ready = 1, then go to IDLE at that edge.
  - rsp data stays stable while valid is high and ready is low.
- rsp*_c/zero/sgn show c_q/zero_q/sgn_q in every state; only valid qualifies them.
- Latency: handshake at cycle T, rsp_valid from T+2. With rsp_ready held at 1, the next grant is possible at T+3. Peak throughput is one op per 3 cycles.
- Back-pressure: while EXEC or RESP, both req_ready = 0. Requests may wait indefinitely, and their op/a/b are sampled only at the handshake cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. A port is never starved beyond one transaction of the other port.
- Response ready with no pending response is ignored.
- Reset mid-operation (EXEC or RESP): the transaction is dropped and no response is produced. FSM returns to IDLE and last_q = 1 on the next edge.
- No width conversion: operands and result are passed unmodified; zero and sgn come from the ALU, registered.

Test Plan:
- Single op, port 0: op=ADD, a=5, b=7, rsp0_ready=1 -> req0_ready=1 at T, rsp0_valid=1 at T+2 with c=12, zero=0, sgn=0; rsp1_valid stays 0.
- Tie after reset: both valid at the same cycle (port0 SUB 3-3, port1 XOR 0xF0F0F0F0^0x0F0F0F0F) -> port 0 first gives c=0, zero=1; then port 1 gives c=0xFFFFFFFF, sgn=1.
- Continuous contention, 8 ops per port -> grants alternate 0,1,...; every response is routed to the issuing port; each grant is 3 cycles after the previous one.
- Back-pressure: port 1 SRA 0x80000000 by 4 with rsp1_ready=0 for 5 cycles -> rsp1_valid held with c=0xF8000000, stable; both req_ready=0 throughout; accepts again the cycle after rsp1_ready rises.
- Shift amount masking: port 0 SLL a=1, b=0x21 -> c=2, driven exactly as supplied; alu_b observed = 0x21.
- Reset in EXEC: assert rst for 1 cycle after a port 0 handshake -> no rsp0_valid ever; next tie grants port 0.
